// File: rtl/fft_bfly_unit.sv
// Pipelined radix-2 butterfly: X = A + W*B, Y = A - W*B, written back in place.
// Define FFT_BFLY_SCALE_EN for per-stage halving with round-half-up; otherwise outputs saturate.
module fft_bfly_unit #(
  parameter int N_SAMPLES = 8,
  parameter int DATA_W    = 16,
  parameter int TW_W      = 16,
  parameter int AW        = $clog2(N_SAMPLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       addr1,
  input  logic [AW-1:0]       addr2,
  input  logic [AW-1:0]       addrT,
  input  logic [AW-1:0]       stage,
  input  logic                in_last,
  output logic [AW-1:0]       rd_addr_a,
  output logic [AW-1:0]       rd_addr_b,
  input  logic [2*DATA_W-1:0] rd_data_a,
  input  logic [2*DATA_W-1:0] rd_data_b,
  output logic [AW-2:0]       tw_addr,
  input  logic [2*TW_W-1:0]   tw_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr_a,
  output logic [AW-1:0]       wr_addr_b,
  output logic [2*DATA_W-1:0] wr_data_a,
  output logic [2*DATA_W-1:0] wr_data_b,
  output logic                busy,
  output logic                done
);

  localparam int PW = DATA_W + TW_W + 1;
  localparam int SW = DATA_W + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);
`ifndef FFT_BFLY_SCALE_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_W - 1)));
`endif

  logic                     p0_valid, p0_last;
  logic                     p1_valid, p1_last;
  logic                     p2_valid, p2_last;
  logic                     wr_last;
  logic [AW-1:0]            p1_a1, p1_a2, p2_a1, p2_a2;
  logic signed [DATA_W-1:0] p2_a_re, p2_a_im;
  logic signed [DATA_W:0]   p2_wb_re, p2_wb_im;
  logic [AW-1:0]            last_stage;
  logic                     first_seen;
  logic                     accept;
  logic                     unused_addrt_msb;

  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PW-1:0]     prod_re, prod_im;
  logic signed [DATA_W:0]   wb_re, wb_im;
  logic signed [SW-1:0]     x_re, x_im, y_re, y_im;

  assign unused_addrt_msb = addrT[AW-1];

  // busy covers tuples not yet presented on the write port; a new stage may be
  // accepted in the write cycle because its RAM read lands one edge after that write.
  assign busy     = p0_valid | p1_valid | p2_valid;
  assign in_ready = !(in_valid && first_seen && (stage != last_stage) && busy);
  assign accept   = in_valid & in_ready;

  assign a_re = rd_data_a[2*DATA_W-1:DATA_W];
  assign a_im = rd_data_a[DATA_W-1:0];
  assign b_re = rd_data_b[2*DATA_W-1:DATA_W];
  assign b_im = rd_data_b[DATA_W-1:0];
  assign w_re = tw_data[2*TW_W-1:TW_W];
  assign w_im = tw_data[TW_W-1:0];

  assign prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + RND;
  assign prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + RND;
  assign wb_re   = (DATA_W + 1)'(prod_re >>> (TW_W - 1));
  assign wb_im   = (DATA_W + 1)'(prod_im >>> (TW_W - 1));

  always_comb begin
    x_re = SW'(p2_a_re) + SW'(p2_wb_re);
    x_im = SW'(p2_a_im) + SW'(p2_wb_im);
    y_re = SW'(p2_a_re) - SW'(p2_wb_re);
    y_im = SW'(p2_a_im) - SW'(p2_wb_im);
  end

  function automatic logic [DATA_W-1:0] conv(input logic signed [SW-1:0] s);
`ifdef FFT_BFLY_SCALE_EN
    logic signed [SW-1:0] r;
    r = (s + SW'(1)) >>> 1;
    return DATA_W'(r);
`else
    if (s > SAT_MAX) return DATA_W'(SAT_MAX);
    if (s < SAT_MIN) return DATA_W'(SAT_MIN);
    return DATA_W'(s);
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_valid   <= 1'b0;
      p0_last    <= 1'b0;
      p1_valid   <= 1'b0;
      p1_last    <= 1'b0;
      p2_valid   <= 1'b0;
      p2_last    <= 1'b0;
      wr_last    <= 1'b0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      tw_addr    <= '0;
      p1_a1      <= '0;
      p1_a2      <= '0;
      p2_a1      <= '0;
      p2_a2      <= '0;
      p2_a_re    <= '0;
      p2_a_im    <= '0;
      p2_wb_re   <= '0;
      p2_wb_im   <= '0;
      wr_en      <= 1'b0;
      wr_addr_a  <= '0;
      wr_addr_b  <= '0;
      wr_data_a  <= '0;
      wr_data_b  <= '0;
      done       <= 1'b0;
      last_stage <= '0;
      first_seen <= 1'b0;
    end else begin
      p0_valid <= accept;
      p0_last  <= accept & in_last;
      if (accept) begin
        rd_addr_a  <= addr1;
        rd_addr_b  <= addr2;
        tw_addr    <= addrT[AW-2:0];
        last_stage <= stage;
        first_seen <= 1'b1;
      end
      // RAM/ROM data appear while the tuple sits in p1
      p1_valid  <= p0_valid;
      p1_last   <= p0_last;
      p1_a1     <= rd_addr_a;
      p1_a2     <= rd_addr_b;
      p2_valid  <= p1_valid;
      p2_last   <= p1_last;
      p2_a1     <= p1_a1;
      p2_a2     <= p1_a2;
      p2_a_re   <= a_re;
      p2_a_im   <= a_im;
      p2_wb_re  <= wb_re;
      p2_wb_im  <= wb_im;
      wr_en     <= p2_valid;
      wr_last   <= p2_last;
      wr_addr_a <= p2_a1;
      wr_addr_b <= p2_a2;
      wr_data_a <= {conv(x_re), conv(x_im)};
      wr_data_b <= {conv(y_re), conv(y_im)};
      done      <= wr_en & wr_last;
    end
  end

endmodule
